pipe_exec_unit: RTL and testbench
=================================

Name: pipe_exec_unit

Overview:
- Parametrised execute stage for the 64-bit pipelined datapath; successor to the fixed single-cycle ALU path.
- Computes the ALU result for the operation selected by alu_ctrl on XLEN-bit operands, then carries the result, zero flag and destination tag through STAGES register slices.
- Adds valid/ready backpressure, flush and occupancy reporting, so the hazard unit can stall or squash in-flight operations.

Parameters:
XLEN, 64, operand/result width in bits (legal values 32 or 64)
STAGES, 2, result latency in cycles (1..4)
TAG_W, 5, width of the destination-register tag carried alongside each result

Ports:
clock  input  1  rising-edge clock, the only clock
reset  input  1  synchronous, active-low reset (sampled on clock rise; 0 = reset)
in_valid  input  1  operation present on the inputs
in_ready  output  1  unit accepts an operation this cycle
alu_ctrl  input  4  operation select
op_a  input  XLEN  operand A
op_b  input  XLEN  operand B
in_tag  input  TAG_W  destination tag
flush  input  1  squash all in-flight operations
out_valid  output  1  result present at the output
out_ready  input  1  consumer accepts the result
ALU_result  output  XLEN  result of the oldest operation
zero  output  1  ALU_result == 0
out_tag  output  TAG_W  tag of the oldest operation
occupancy  output  3  number of valid slices (0..STAGES)

Behaviour:
- alu_ctrl encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB
  - 0111 SLT (signed; result 1 or 0, zero-extended to XLEN)
  - 1100 NOR
  - any other code gives result 0; no error flag.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN; there are no overflow or carry outputs.
- Compute is combinational from inputs into slice 0. Slices 1..STAGES-1 are pure shift registers, each holding {valid, result, zero, tag}.
- advance = !out_valid | out_ready. While advance=1, every slice shifts one step and slice 0 loads {in_valid, computed result, zero, in_tag}. While advance=0, all slices hold.
- in_ready = advance. It is combinational from out_valid/out_ready and does not depend on in_valid.
- Latency: an operation accepted in cycle N appears with out_valid=1 in cycle N+STAGES, provided there are no stalls.
- Throughput: one operation per cycle while out_ready=1.
- Bubbles (in_valid=0 while advance=1) propagate as invalid slices. Bubbles are compressed only by the normal shift; there is no skid or collapse.
- Outputs ALU_result, zero and out_tag come from the last slice. When out_valid=0 their values are don't-care, but they must equal the registered last-slice contents, never X after reset.
- flush=1: on the next clock every valid bit clears, so occupancy becomes 0 and out_valid becomes 0.
  - flush has priority over capture; an operation offered in the flush cycle is dropped even if in_ready=1.
  - Data fields may keep stale values.
- Simultaneous flush and out_ready: the result currently presented counts as consumed by the consumer. The unit itself just clears.
- occupancy: registered count of valid slices, updated each clock.
  - Rises by 1 when slice 0 loads a valid operation and no valid result leaves.
  - Falls by 1 when a valid result leaves and no valid operation enters.
  - Is unchanged when one enters and one leaves in the same cycle.
  - Goes to 0 on flush or reset.
- Reset (reset=0 at a clock edge):
  - All valid bits, data fields, tags and occupancy clear to 0.
  - Hence out_valid=0, ALU_result=0, zero=1, out_tag=0.
  - in_ready=1 from the first cycle after reset.
  - Reset in mid-operation discards all in-flight operations and overrides flush.
- STAGES=1: slice 0 is also the output slice and the shift chain is absent.

Decomposition:
- Shared package pipe_pkg:
  - alu_ctrl encoding constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR
  - CTRL_W = 4
  - the slice record typedef {valid, result, zero, tag}
- One sub-module: alu_core, purely combinational, taking (alu_ctrl, op_a, op_b) and producing (result, zero).
- pipe_exec_unit holds the slice array, advance/flush logic and occupancy counter.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release -> out_valid=0, occupancy=0, ALU_result=0, zero=1, in_ready=1.
- Ops at STAGES=2, XLEN=64:
  - ADD 5+7, tag 3, out_ready=1 -> cycle N+2 gives ALU_result=12, zero=0, out_tag=3.
  - SUB 9-9 -> result 0, zero=1.
  - SLT(-1,1) -> 1.
  - ADD 0xFFFF_FFFF_FFFF_FFFF + 1 -> 0, zero=1.
  - alu_ctrl=1111 -> 0.
- Back-to-back: 4 consecutive ADDs with out_ready=1 -> 4 consecutive out_valid cycles, in order, occupancy steady at 2.
- Backpressure: fill the pipe, drop out_ready for 3 cycles -> in_ready=0, outputs stable and unchanged, occupancy=2; restore out_ready -> results drain in order with none lost or duplicated.
- Flush: two valid ops in flight plus in_valid=1 with flush=1 -> next cycle occupancy=0, out_valid=0, and the flushed ops never appear.
- Reset mid-stream: reset=0 while occupancy=2 and out_ready=0 -> next cycle everything clears; the first op after release emerges with correct latency.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined execute stage: ALU opcodes, widths and
// the register-slice record carried down the result pipeline.
package pipe_pkg;

    localparam int CTRL_W    = 4;
    localparam int XLEN_MAX  = 64;
    localparam int TAG_W_MAX = 16;
    localparam int OCC_W     = 3;

    typedef enum logic [CTRL_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_op_e;

    // Fields are sized for the widest legal configuration; narrower units
    // zero-extend on load and use the low bits on output.
    typedef struct packed {
        logic                 valid;
        logic [XLEN_MAX-1:0]  result;
        logic                 zero;
        logic [TAG_W_MAX-1:0] tag;
    } slice_t;

endpackage

// File: rtl/pipe_exec_unit_alu_core.sv
// Combinational ALU: result and zero flag for the operation selected by
// alu_ctrl. Unknown codes yield 0.
module alu_core
    import pipe_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [CTRL_W-1:0] alu_ctrl,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    output logic [XLEN-1:0]   result,
    output logic              zero
);

    always_comb begin
        // NOTE: default assigned first so no path leaves result unassigned (no latch).
        result = '0;
        case (alu_ctrl)
            ALU_AND: result = op_a & op_b;
            ALU_OR:  result = op_a | op_b;
            ALU_ADD: result = op_a + op_b;
            ALU_SUB: result = op_a - op_b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_NOR: result = ~(op_a | op_b);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/pipe_exec_unit.sv
// Execute stage: ALU into slice 0, then a STAGES-deep register chain with
// valid/ready backpressure, flush and an occupancy count.
module pipe_exec_unit
    import pipe_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] alu_ctrl,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   ALU_result,
    output logic              zero,
    output logic [TAG_W-1:0]  out_tag,
    output logic [OCC_W-1:0]  occupancy
);

    localparam slice_t SLICE_RESET = '{valid: 1'b0, result: '0, zero: 1'b1, tag: '0};

    slice_t            slice_q [STAGES];
    slice_t            last_slice;
    slice_t            new_slice;
    logic [XLEN-1:0]   alu_res;
    logic              alu_zero;
    logic              advance;
    logic              enter;
    logic              leave;
    logic [OCC_W-1:0]  occ_q;

    alu_core #(.XLEN(XLEN)) u_alu (
        .alu_ctrl (alu_ctrl),
        .op_a     (op_a),
        .op_b     (op_b),
        .result   (alu_res),
        .zero     (alu_zero)
    );

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign enter    = in_valid && advance;
    assign leave    = out_valid && out_ready;

    assign new_slice = '{valid:  in_valid,
                         result: XLEN_MAX'(alu_res),
                         zero:   alu_zero,
                         tag:    TAG_W_MAX'(in_tag)};

    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: data fields are reset too, so outputs are defined (0/zero=1) rather than X.
            for (int i = 0; i < STAGES; i++) slice_q[i] <= SLICE_RESET;
        end else if (flush) begin
            for (int i = 0; i < STAGES; i++) slice_q[i].valid <= 1'b0;
        end else if (advance) begin
            for (int i = STAGES - 1; i > 0; i--) slice_q[i] <= slice_q[i-1];
            slice_q[0] <= new_slice;
        end
    end

    // Occupancy tracks the valid bits: +1 on entry only, -1 on exit only.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            occ_q <= '0;
        end else begin
            case ({enter, leave})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign last_slice = slice_q[STAGES-1];
    assign out_valid  = last_slice.valid;
    assign ALU_result = last_slice.result[XLEN-1:0];
    assign zero       = last_slice.zero;
    assign out_tag    = last_slice.tag[TAG_W-1:0];
    assign occupancy  = occ_q;

    // Upper record bits of the output slice are always zero in narrow builds.
    if (XLEN < XLEN_MAX) begin : g_res_pad
        logic unused_res_pad;
        assign unused_res_pad = ^last_slice.result[XLEN_MAX-1:XLEN];
    end
    if (TAG_W < TAG_W_MAX) begin : g_tag_pad
        logic unused_tag_pad;
        assign unused_tag_pad = ^last_slice.tag[TAG_W_MAX-1:TAG_W];
    end

endmodule

// File: tb/tb_pipe_exec_unit.sv
// Directed self-checking bench for pipe_exec_unit (XLEN=64, STAGES=2, TAG_W=5).
module tb_pipe_exec_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] ALU_result;
    logic        zero;
    logic [4:0]  out_tag;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_exec_unit #(.XLEN(64), .STAGES(2), .TAG_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_ctrl   (alu_ctrl),
        .op_a       (op_a),
        .op_b       (op_b),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALU_result (ALU_result),
        .zero       (zero),
        .out_tag    (out_tag),
        .occupancy  (occupancy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  ctrl;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  tag;
        logic [63:0] res;
        logic        zero;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] t);
        in_valid = v;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        in_tag   = t;
    endtask

    initial begin
        vecs[0] = '{4'b0010, 64'd5, 64'd7, 5'd3, 64'd12, 1'b0};
        vecs[1] = '{4'b0110, 64'd9, 64'd9, 5'd4, 64'd0, 1'b1};
        vecs[2] = '{4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd5, 64'd1, 1'b0};
        vecs[3] = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd6, 64'd0, 1'b1};
        vecs[4] = '{4'b1111, 64'd5, 64'd7, 5'd7, 64'd0, 1'b1};
        vecs[5] = '{4'b0000, 64'hF0F0, 64'hFF00, 5'd8, 64'hF000, 1'b0};
        vecs[6] = '{4'b0001, 64'hF0F0, 64'h0F0F, 5'd9, 64'hFFFF, 1'b0};
        vecs[7] = '{4'b1100, 64'd0, 64'd0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[8] = '{4'b0111, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11, 64'd0, 1'b1};
        vecs[9] = '{4'b0110, 64'd0, 64'd1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

        reset = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 4'b0, 64'd0, 64'd0, 5'd0);

        // Reset state
        step();
        step();
        reset = 1'b1;
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset occupancy", 64'(occupancy), 64'd0);
        check("reset ALU_result", ALU_result, 64'd0);
        check("reset zero", 64'(zero), 64'd1);
        check("reset out_tag", 64'(out_tag), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);

        // Single operations, two-cycle latency
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].tag);
            step();
            drive(1'b0, 4'b0, 64'd0, 64'd0, 5'd0);
            check($sformatf("vec%0d early out_valid", i), 64'(out_valid), 64'd0);
            step();
            check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d result", i), ALU_result, vecs[i].res);
            check($sformatf("vec%0d zero", i), 64'(zero), 64'(vecs[i].zero));
            check($sformatf("vec%0d tag", i), 64'(out_tag), 64'(vecs[i].tag));
            step();
            check($sformatf("vec%0d drained", i), 64'(out_valid), 64'd0);
        end

        // Back-to-back ADDs: i + 100, tags 10..13
        for (int k = 1; k <= 7; k++) begin
            if (k <= 4) drive(1'b1, 4'b0010, 64'(k - 1), 64'd100, 5'(9 + k));
            else        drive(1'b0, 4'b0, 64'd0, 64'd0, 5'd0);
            step();
            check($sformatf("b2b out_valid k%0d", k), 64'(out_valid), (k >= 2 && k <= 5) ? 64'd1 : 64'd0);
            if (k >= 2 && k <= 5) begin
                check($sformatf("b2b result k%0d", k), ALU_result, 64'(100 + k - 2));
                check($sformatf("b2b tag k%0d", k), 64'(out_tag), 64'(10 + k - 2));
            end
            if (k >= 2 && k <= 4) check($sformatf("b2b occupancy k%0d", k), 64'(occupancy), 64'd2);
        end
        check("b2b occupancy empty", 64'(occupancy), 64'd0);

        // Backpressure: A=1+2 (tag 20), B=10+20 (tag 21), C=50-8 (tag 22)
        out_ready = 1'b0;
        drive(1'b1, 4'b0010, 64'd1, 64'd2, 5'd20);
        step();
        drive(1'b1, 4'b0010, 64'd10, 64'd20, 5'd21);
        step();
        drive(1'b1, 4'b0110, 64'd50, 64'd8, 5'd22);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("bp in_ready s%0d", s), 64'(in_ready), 64'd0);
            check($sformatf("bp out_valid s%0d", s), 64'(out_valid), 64'd1);
            check($sformatf("bp result s%0d", s), ALU_result, 64'd3);
            check($sformatf("bp tag s%0d", s), 64'(out_tag), 64'd20);
            check($sformatf("bp occupancy s%0d", s), 64'(occupancy), 64'd2);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 64'(in_ready), 64'd1);
        check("bp release tag", 64'(out_tag), 64'd20);
        step();
        drive(1'b0, 4'b0, 64'd0, 64'd0, 5'd0);
        check("bp drain1 valid", 64'(out_valid), 64'd1);
        check("bp drain1 result", ALU_result, 64'd30);
        check("bp drain1 tag", 64'(out_tag), 64'd21);
        step();
        check("bp drain2 valid", 64'(out_valid), 64'd1);
        check("bp drain2 result", ALU_result, 64'd42);
        check("bp drain2 tag", 64'(out_tag), 64'd22);
        step();
        check("bp drain3 valid", 64'(out_valid), 64'd0);
        check("bp drain3 occupancy", 64'(occupancy), 64'd0);

        // Flush with two in flight and a third offered
        out_ready = 1'b0;
        drive(1'b1, 4'b0010, 64'd1, 64'd1, 5'd1);
        step();
        drive(1'b1, 4'b0010, 64'd2, 64'd2, 5'd2);
        step();
        check("flush pre occupancy", 64'(occupancy), 64'd2);
        drive(1'b1, 4'b0010, 64'd3, 64'd3, 5'd3);
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 4'b0, 64'd0, 64'd0, 5'd0);
        check("flush occupancy", 64'(occupancy), 64'd0);
        check("flush out_valid", 64'(out_valid), 64'd0);
        for (int s = 0; s < 4; s++) begin
            step();
            check($sformatf("flush quiet s%0d", s), 64'(out_valid), 64'd0);
        end

        // Reset mid-stream
        out_ready = 1'b0;
        drive(1'b1, 4'b0010, 64'd7, 64'd7, 5'd17);
        step();
        drive(1'b1, 4'b0010, 64'd8, 64'd8, 5'd18);
        step();
        check("rst-mid pre occupancy", 64'(occupancy), 64'd2);
        drive(1'b0, 4'b0, 64'd0, 64'd0, 5'd0);
        reset = 1'b0;
        flush = 1'b1;
        step();
        reset = 1'b1;
        flush = 1'b0;
        #1;
        check("rst-mid occupancy", 64'(occupancy), 64'd0);
        check("rst-mid out_valid", 64'(out_valid), 64'd0);
        check("rst-mid ALU_result", ALU_result, 64'd0);
        check("rst-mid zero", 64'(zero), 64'd1);
        check("rst-mid out_tag", 64'(out_tag), 64'd0);
        check("rst-mid in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        drive(1'b1, 4'b0010, 64'd40, 64'd2, 5'd9);
        step();
        drive(1'b0, 4'b0, 64'd0, 64'd0, 5'd0);
        check("post-rst early valid", 64'(out_valid), 64'd0);
        step();
        check("post-rst valid", 64'(out_valid), 64'd1);
        check("post-rst result", ALU_result, 64'd42);
        check("post-rst tag", 64'(out_tag), 64'd9);
        step();
        check("post-rst drained", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
